// File: rtl/pwm_wave_gen.sv
// Multi-channel PWM generator: shared counter/phase/amplitude, per-channel waveform duty.
// Pulse is registered (1 cycle after cnt); duty reloads only at the period boundary; no backpressure.
module pwm_wave_gen #(
  parameter int CNT_W = 6,
  parameter int PH_W  = 6,
  parameter int NCH   = 2
) (
  input  logic             sysclk,
  input  logic             rst,
  input  logic [NCH-1:0]   enable,
  input  logic [2*NCH-1:0] mode,
  output logic [NCH-1:0]   pulse,
  output logic             period_tick
);

  // Place a phase-width value in the top bits of a counter-width word.
  function automatic logic [CNT_W-1:0] lalign(input logic [PH_W-1:0] x);
    logic [CNT_W+PH_W-1:0] w;
    w = {x, {CNT_W{1'b0}}};
    return w[CNT_W+PH_W-1 -: CNT_W];
  endfunction

  logic             run;
  logic [CNT_W-1:0] cnt;
  logic [PH_W-1:0]  ph;
  logic [PH_W-1:0]  amp;
  logic [PH_W-1:0]  ph_nxt;
  logic [PH_W-1:0]  amp_nxt;
  logic [PH_W-1:0]  tri_t;
  logic             pb;
  logic             sq_win;
  logic [CNT_W-1:0] sq_tgt;
  logic [CNT_W-1:0] saw_tgt;
  logic [CNT_W-1:0] tri_tgt;
  logic [CNT_W-1:0] con_tgt;

  assign pb          = &cnt;
  assign period_tick = pb;

  // Targets are built from the phase/amplitude that become valid at this boundary.
  always_comb begin
    ph_nxt  = ph + PH_W'(1);
    amp_nxt = (&ph) ? amp + PH_W'(1) : amp;
    sq_win  = ph_nxt[PH_W-1] ^ ph_nxt[PH_W-2];
    tri_t   = {ph_nxt[PH_W-2:0], 1'b0};
    sq_tgt  = sq_win ? lalign(amp_nxt) : '0;
    saw_tgt = lalign(ph_nxt);
    tri_tgt = lalign(ph_nxt[PH_W-1] ? ~tri_t : tri_t);
    con_tgt = lalign(amp_nxt);
  end

  // First edge after reset release holds cnt at 0 so a full period precedes the first tick.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      run <= 1'b0;
      cnt <= '0;
    end else begin
      run <= 1'b1;
      if (run) cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      ph  <= '0;
      amp <= '0;
    end else if (pb) begin
      ph  <= ph_nxt;
      amp <= amp_nxt;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [1:0]       sel;
    logic [CNT_W-1:0] tgt;
    logic [CNT_W-1:0] duty;

    assign sel = mode[2*i +: 2];

    always_comb begin
      tgt = '0;
      unique case (sel)
        2'b00: tgt = sq_tgt;
        2'b01: tgt = saw_tgt;
        2'b10: tgt = tri_tgt;
        2'b11: tgt = con_tgt;
      endcase
    end

    always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
        duty     <= '0;
        pulse[i] <= 1'b0;
      end else begin
        if (pb) duty <= tgt;
        pulse[i] <= enable[i] & (cnt < duty);
      end
    end
  end

endmodule

// File: tb/tb_pwm_wave_gen.sv
// Directed bench for pwm_wave_gen at default parameters; high time is measured per period window.
module tb_pwm_wave_gen;

  logic       sysclk;
  logic       rst;
  logic [1:0] enable;
  logic [3:0] mode;
  logic [1:0] pulse;
  logic       period_tick;

  int checks;
  int errors;
  int cyc;
  int first_tick;
  int h0;
  int h1;

  pwm_wave_gen #(.CNT_W(6), .PH_W(6), .NCH(2)) dut (
    .sysclk      (sysclk),
    .rst         (rst),
    .enable      (enable),
    .mode        (mode),
    .pulse       (pulse),
    .period_tick (period_tick)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: count the edge, then sample at the following falling edge.
  task automatic tick();
    @(posedge sysclk);
    cyc++;
    @(negedge sysclk);
    if (period_tick === 1'b1 && first_tick < 0) first_tick = cyc;
  endtask

  task automatic goto(input int target);
    while (cyc < target) tick();
    check("align", cyc, target);
  endtask

  // Pass n (ph = n mod 64) drives pulse during the samples after edges 2+64n .. 65+64n.
  task automatic measure(input int n, output int m0, output int m1);
    goto(1 + 64 * n);
    m0 = 0;
    m1 = 0;
    repeat (64) begin
      tick();
      m0 += int'(pulse[0]);
      m1 += int'(pulse[1]);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    cyc        = 0;
    first_tick = -1;
    enable     = 2'b11;
    mode       = {2'b01, 2'b11};
    rst        = 1'b0;
    #1 rst     = 1'b1;
    #3;
    check("rst_pulse", pulse, 0);
    check("rst_tick", period_tick, 0);
    @(negedge sysclk);
    @(negedge sysclk);
    check("rst_hold_pulse", pulse, 0);
    #2 rst = 1'b0;

    // Constant mode on ch0 stays dark while amp=0; sawtooth on ch1 follows ph.
    measure(0, h0, h1);
    check("p0_ch0", h0, 0);
    check("p0_ch1", h1, 0);
    check("first_tick", first_tick, 64);
    measure(1, h0, h1);
    check("saw_ph1", h1, 1);
    check("const_amp0_p1", h0, 0);
    measure(5, h0, h1);
    check("saw_ph5", h1, 5);
    measure(63, h0, h1);
    check("saw_ph63", h1, 63);
    check("const_amp0_p63", h0, 0);
    measure(64, h0, h1);
    check("saw_ph0", h1, 0);
    check("const_amp1_p64", h0, 1);
    measure(65, h0, h1);
    check("const_amp1_p65", h0, 1);

    // Triangle on ch1.
    mode[3:2] = 2'b10;
    measure(95, h0, h1);
    check("tri_ph31", h1, 62);
    measure(96, h0, h1);
    check("tri_ph32", h1, 63);
    measure(104, h0, h1);
    check("tri_ph40", h1, 47);
    measure(127, h0, h1);
    check("tri_ph63", h1, 1);
    check("const_amp1_p127", h0, 1);
    measure(128, h0, h1);
    check("tri_ph0", h1, 0);
    check("const_amp2", h0, 2);

    // Gated square on ch0 with amp=5.
    mode[1:0] = 2'b00;
    measure(335, h0, h1);
    check("sq_ph15", h0, 0);
    check("tri_ph15", h1, 30);
    measure(336, h0, h1);
    check("sq_ph16", h0, 5);
    check("tri_ph16", h1, 32);
    measure(367, h0, h1);
    check("sq_ph47", h0, 5);
    check("tri_ph47", h1, 33);
    measure(368, h0, h1);
    check("sq_ph48", h0, 0);
    check("tri_ph48", h1, 31);

    // ph and amp wrap together: 5 -> 6 with ph 63 -> 0.
    mode[1:0] = 2'b11;
    measure(383, h0, h1);
    check("const_amp5", h0, 5);
    measure(384, h0, h1);
    check("const_amp6_wrap", h0, 6);

    // Mid-period mode switch on ch0 (sawtooth -> constant).
    mode = {2'b01, 2'b01};
    goto(1 + 64 * 488);
    h0 = 0;
    h1 = 0;
    for (int s = 1; s <= 64; s++) begin
      tick();
      h0 += int'(pulse[0]);
      h1 += int'(pulse[1]);
      if (s == 20) mode[1:0] = 2'b11;
    end
    check("switch_old_duty", h0, 40);
    check("switch_ch1", h1, 40);
    measure(489, h0, h1);
    check("switch_new_duty", h0, 7);
    check("saw_ph41", h1, 41);

    // Drop enable[1] while it is high; ch0 must not notice.
    goto(1 + 64 * 490);
    h0 = 0;
    h1 = 0;
    for (int s = 1; s <= 64; s++) begin
      tick();
      h0 += int'(pulse[0]);
      h1 += int'(pulse[1]);
      if (s == 10) begin
        check("ch1_high_before_drop", pulse[1], 1);
        enable[1] = 1'b0;
      end
      if (s == 11) check("ch1_low_next_edge", pulse[1], 0);
    end
    check("disable_ch0", h0, 7);
    check("disable_ch1", h1, 10);
    enable[1] = 1'b1;
    measure(491, h0, h1);
    check("reenable_ch1", h1, 43);
    check("reenable_ch0", h0, 7);

    // Asynchronous reset in the middle of a high pulse.
    goto(1 + 64 * 492);
    repeat (3) tick();
    check("pre_rst_pulse", pulse, 3);
    #2 rst = 1'b1;
    #1;
    check("async_rst_pulse", pulse, 0);
    check("async_rst_tick", period_tick, 0);
    tick();
    tick();
    check("rst_held_pulse", pulse, 0);
    #2 rst = 1'b0;
    cyc        = 0;
    first_tick = -1;
    measure(0, h0, h1);
    check("post_rst_p0_ch0", h0, 0);
    check("post_rst_p0_ch1", h1, 0);
    check("post_rst_first_tick", first_tick, 64);
    measure(1, h0, h1);
    check("post_rst_const", h0, 0);
    check("post_rst_saw_ph1", h1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_wave_gen.md
PWM_WAVE_GEN -- requirements
Module: pwm_wave_gen

Interface
REQ-001 The block SHALL have parameter CNT_W, default 6: PWM counter and duty width in bits (>=2).
REQ-002 The block SHALL have parameter PH_W, default 6: phase-index and amplitude-index width in bits (>=2).
REQ-003 The block SHALL have parameter NCH, default 2: number of independent output channels (>=1).
REQ-004 The block SHALL have port sysclk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port enable, input, NCH bits: per-channel output enable.
REQ-007 The block SHALL have port mode, input, 2*NCH bits: per-channel waveform select; channel i uses mode[2i+1:2i].
REQ-008 The block SHALL have port pulse, output, NCH bits: per-channel registered PWM output.
REQ-009 The block SHALL have port period_tick, output, 1 bit: high for one cycle while cnt is all-ones.

Function
REQ-010 cnt (CNT_W bits) SHALL increment every cycle and wrap from 2^CNT_W-1 to 0.
REQ-011 The period boundary (PB) SHALL be the cycle with cnt all-ones; period_tick SHALL be combinational (cnt == all-ones).
REQ-012 ph (PH_W bits) SHALL increment on every PB and wrap to 0.
REQ-013 amp (PH_W bits) SHALL increment on a PB in which ph is all-ones, and wrap to 0; the update SHALL be synchronous (no level-sensitive logic).
REQ-014 Left-align, L(x): a PH_W-bit value mapped to CNT_W bits; if PH_W>=CNT_W, take the top CNT_W bits; otherwise append zero LSBs.
REQ-015 mode 00, gated square: target duty SHALL be L(amp) when 2^PH_W/4 <= ph < 3*2^PH_W/4, else 0.
REQ-016 mode 01, sawtooth: target duty SHALL be L(ph).
REQ-017 mode 10, triangle: t = (ph<<1) truncated to PH_W bits; target duty SHALL be L(ph MSB ? ~t : t).
REQ-018 mode 11, constant: target duty SHALL be L(amp).
REQ-019 Targets SHALL use the ph/amp values valid after the PB update.
REQ-020 Each channel's duty register (CNT_W bits) SHALL load its target only on a PB.
  - mode changes mid-period take effect from the next period only.
  - no glitches.
REQ-021 pulse[i] SHALL be registered: pulse[i] <= enable[i] & (cnt < duty[i]).
  - one cycle of latency from cnt to pulse.
  - maximum high time is 2^CNT_W-1 cycles per period (100% is unreachable, by design).
REQ-022 Deasserting enable[i] SHALL force pulse[i] low at the next edge.
  - cnt, ph, amp and duty keep running.
  - re-enable resumes in-phase.
REQ-023 Channels SHALL be fully independent except for the shared cnt, ph and amp.
REQ-024 Concurrent ph and amp wrap on the same PB SHALL both occur; next target uses ph=0 and amp+1 (mod 2^PH_W).

Reset
REQ-025 While rst is high, cnt, ph, amp, every duty[i] and every pulse[i] SHALL be 0 immediately (asynchronously).
REQ-026 After rst release, cnt SHALL be 0 at the first active edge and count from there.
REQ-027 rst asserted mid-period SHALL abort the current period; no partial pulse is emitted after rst is asserted.

Verification (defaults CNT_W=6, PH_W=6, NCH=2)
REQ-028 Stimulus: assert rst mid-high-pulse, asynchronously to the clock -> pulse drops to 0 without waiting for a clock edge; after release, period_tick first rises 64 cycles later.
REQ-029 Stimulus: mode 11, enable=1 from reset -> pulse=0 for the first 4096+ cycles (amp=0); after amp=1, high 1 of every 64 cycles.
REQ-030 Stimulus: mode 01 -> in the period with ph=k, pulse high exactly k cycles (k=0 gives none; k=63 gives 63).
REQ-031 Stimulus: mode 10 -> high times per ph: ph=31 gives 62, ph=32 gives 63, ph=40 gives 47, ph=63 gives 1.
REQ-032 Stimulus: mode 00 with amp=5 -> pulse 0 for ph 0..15 and 48..63; high 5 cycles for ph 16..47.
REQ-033 Stimulus: channel 0 mode switched 01->11 mid-period, then enable[1] dropped -> ch0 period finishes at the old duty then switches at the PB; ch1 goes low next edge; ch0 is unaffected.
